// File: rtl/stdp_count_sequencer_pkg.sv
// Shared defaults, delta lookup contents and sweep state encoding for the
// STDP count sequencer.
package stdp_pkg;

    localparam int unsigned STDP_CNT_W = 8;
    localparam int unsigned STDP_DW_W  = 24;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } seq_state_t;

    // Potentiation grows linearly with spike count, depression quadratically.
    function automatic logic [31:0] ltp_delta(input int unsigned cnt);
        return 32'(1000 + 7 * cnt);
    endfunction

    function automatic logic [31:0] ltd_delta(input int unsigned cnt);
        return 32'(cnt * cnt + 3);
    endfunction

endpackage

// File: rtl/stdp_count_sequencer_delta_lut.sv
// Constant ROM of LTP/LTD deltas indexed by spike count, with a registered,
// enable-gated output so it can freeze together with the sweep pipeline.
module stdp_delta_lut
    import stdp_pkg::*;
#(
    parameter int unsigned CNT_W = STDP_CNT_W,
    parameter int unsigned DW_W  = STDP_DW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_addr,
    output logic [DW_W-1:0]  o_plus,
    output logic [DW_W-1:0]  o_minus
);

    localparam int DEPTH = 2 ** CNT_W;

    logic [DW_W-1:0] w_rom_plus  [DEPTH];
    logic [DW_W-1:0] w_rom_minus [DEPTH];
    logic [DW_W-1:0] r_plus;
    logic [DW_W-1:0] r_minus;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign w_rom_plus[g]  = DW_W'(ltp_delta(g));
        assign w_rom_minus[g] = DW_W'(ltd_delta(g));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_plus  <= '0;
            r_minus <= '0;
        end else if (i_en) begin
            r_plus  <= w_rom_plus[i_addr];
            r_minus <= w_rom_minus[i_addr];
        end
    end

    assign o_plus  = r_plus;
    assign o_minus = r_minus;

endmodule

// File: rtl/stdp_count_sequencer.sv
// Sweeps every pre-synaptic spike count once per queued post-synaptic fire and
// streams LTP/LTD deltas as valid/ready beats in ascending input order.
module stdp_count_sequencer
    import stdp_pkg::*;
#(
    parameter int unsigned N_IN      = 784,
    parameter int unsigned N_POST    = 16,
    parameter int unsigned CNT_W     = STDP_CNT_W,
    parameter int unsigned DW_W      = STDP_DW_W,
    parameter bit          SKIP_ZERO = 1'b0,
    localparam int unsigned IDX_W    = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int unsigned PIDX_W   = (N_POST > 1) ? $clog2(N_POST) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_W*N_IN-1:0] count,
    input  logic [N_POST-1:0]     start_wch,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [IDX_W-1:0]      ip_select,
    output logic [PIDX_W-1:0]     post_idx,
    output logic [DW_W-1:0]       del_w_plus,
    output logic [DW_W-1:0]       del_w_minus,
    output logic                  busy,
    output logic                  done
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [N_POST-1:0] r_pend;
    logic [N_POST-1:0] w_clr;
    logic [IDX_W-1:0]  r_idx;
    logic [PIDX_W-1:0] r_post_idx;
    logic [PIDX_W-1:0] w_low;
    logic              w_any_pend;
    logic              w_stall;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_done;
    logic              w_launch;
    logic [CNT_W-1:0]  w_cnt_sel;
    logic              r_s1_valid;
    logic              r_s1_last;
    logic [IDX_W-1:0]  r_s1_idx;
    logic [CNT_W-1:0]  r_s1_cnt;
    logic              r_s2_valid;
    logic              r_s2_last;
    logic [IDX_W-1:0]  r_s2_idx;

    always_comb begin
        w_low = '0;
        for (int unsigned i = N_POST; i > 0; i--) begin
            if (r_pend[i-1]) w_low = PIDX_W'(i - 1);
        end
    end

    assign w_any_pend   = |r_pend;
    assign w_stall      = r_s2_valid & ~out_ready;
    // The last-index marker travels even when its beat is a skipped bubble,
    // so the sweep ends exactly when that slot leaves the output stage.
    assign w_done       = r_s2_last & ~w_stall;
    assign w_issue      = (r_state == SCAN) & ~w_stall;
    assign w_last_issue = w_issue & (r_idx == IDX_W'(N_IN - 1));
    assign w_cnt_sel    = count[r_idx * CNT_W +: CNT_W];
    assign w_clr        = w_launch ? (N_POST'(1) << w_low) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_pend) begin
                    w_state_nxt = SCAN;
                    w_launch    = 1'b1;
                end
            end
            SCAN: begin
                if (w_last_issue) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_done) begin
                    w_state_nxt = w_any_pend ? SCAN : IDLE;
                    w_launch    = w_any_pend;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pend     <= '0;
            r_idx      <= '0;
            r_post_idx <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_cnt   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= (r_pend | start_wch) & ~w_clr;
            if (w_launch) begin
                r_idx      <= '0;
                r_post_idx <= w_low;
            end else if (w_issue && !w_last_issue) begin
                r_idx <= r_idx + 1'b1;
            end
            if (!w_stall) begin
                r_s1_valid <= w_issue & ~(SKIP_ZERO & (w_cnt_sel == '0));
                r_s1_last  <= w_last_issue;
                r_s1_idx   <= r_idx;
                r_s1_cnt   <= w_cnt_sel;
                r_s2_valid <= r_s1_valid;
                r_s2_last  <= r_s1_last;
                r_s2_idx   <= r_s1_idx;
            end
        end
    end

    stdp_delta_lut #(
        .CNT_W (CNT_W),
        .DW_W  (DW_W)
    ) u_lut (
        .clk     (clk),
        .rst     (rst),
        .i_en    (~w_stall),
        .i_addr  (r_s1_cnt),
        .o_plus  (del_w_plus),
        .o_minus (del_w_minus)
    );

    assign out_valid = r_s2_valid;
    assign ip_select = r_s2_idx;
    assign post_idx  = r_post_idx;
    assign busy      = (r_state != IDLE) | w_any_pend;
    assign done      = w_done & ~rst;

endmodule

// File: tb/tb_stdp_count_sequencer.sv
// Bench for stdp_count_sequencer: two instances (plain and zero-skipping) share
// stimulus and are compared every cycle against a transaction-level model.
module tb_stdp_count_sequencer;

    localparam int NI = 8;

    typedef struct {
        int post;
        int ip;
        int plus;
        int minus;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NI*8-1:0]   count;
    logic [15:0]       start_wch;
    logic              out_ready;
    logic [1:0]        ov, bsy, dn;
    logic [1:0][2:0]   ips;
    logic [1:0][3:0]   pix;
    logic [1:0][23:0]  dp, dm;

    int     n_pass = 0;
    int     n_total = 0;
    bit     chk_en = 1'b0;
    logic [7:0] cnt_arr [NI];

    // Model: per instance, sweep cursor, pending set and the two in-flight slots.
    bit          m_act [2];
    int          m_cur [2];
    int          m_post [2];
    logic [15:0] m_pend [2];
    bit          s1v [2], s1l [2], s2v [2], s2l [2];
    int          s1i [2], s2i [2];

    beat_t bq0[$], bq1[$];
    int    dpost0[$], dpost1[$], dip0[$], dov1[$];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        stdp_count_sequencer #(
            .N_IN(NI), .N_POST(16), .CNT_W(8), .DW_W(24), .SKIP_ZERO(k == 1)
        ) dut (
            .clk(clk), .rst(rst), .count(count), .start_wch(start_wch),
            .out_ready(out_ready), .out_valid(ov[k]), .ip_select(ips[k]),
            .post_idx(pix[k]), .del_w_plus(dp[k]), .del_w_minus(dm[k]),
            .busy(bsy[k]), .done(dn[k])
        );
    end

    always #5 clk = ~clk;

    function automatic int ltp(input int c);
        return 1000 + 7 * c;
    endfunction

    function automatic int ltd(input int c);
        return c * c + 3;
    endfunction

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit stall, dnow, launch;
            int low;
            logic [15:0] np;
            if (rst) begin
                m_act[k] = 0; m_cur[k] = 0; m_post[k] = 0; m_pend[k] = '0;
                s1v[k] = 0; s1l[k] = 0; s1i[k] = 0; s2v[k] = 0; s2l[k] = 0; s2i[k] = 0;
            end else begin
                stall  = s2v[k] && !out_ready;
                dnow   = s2l[k] && !stall;
                launch = (m_pend[k] != 0) && (!m_act[k] || dnow);
                low    = lowest(m_pend[k]);
                np     = m_pend[k] | start_wch;
                if (launch) np[low] = 1'b0;
                m_pend[k] = np;
                if (!stall) begin
                    s2v[k] = s1v[k]; s2l[k] = s1l[k]; s2i[k] = s1i[k];
                    if (m_act[k] && m_cur[k] < NI) begin
                        s1v[k] = !(k == 1 && cnt_arr[m_cur[k]] == 0);
                        s1l[k] = (m_cur[k] == NI - 1);
                        s1i[k] = m_cur[k];
                        m_cur[k]++;
                    end else begin
                        s1v[k] = 0; s1l[k] = 0;
                    end
                end
                if (dnow) m_act[k] = 0;
                if (launch) begin
                    m_act[k] = 1; m_cur[k] = 0; m_post[k] = low;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check_eq($sformatf("out_valid[%0d]", k), ov[k], s2v[k]);
                check_eq($sformatf("done[%0d]", k), dn[k], s2l[k] && (!s2v[k] || out_ready) && !rst);
                check_eq($sformatf("busy[%0d]", k), bsy[k], m_act[k] || (m_pend[k] != 0));
                check_eq($sformatf("post_idx[%0d]", k), pix[k], m_post[k]);
                if (s2v[k]) begin
                    check_eq($sformatf("ip_select[%0d]", k), ips[k], s2i[k]);
                    check_eq($sformatf("del_w_plus[%0d]", k), dp[k], ltp(cnt_arr[s2i[k]]));
                    check_eq($sformatf("del_w_minus[%0d]", k), dm[k], ltd(cnt_arr[s2i[k]]));
                end
            end
            if (ov[0] && out_ready) bq0.push_back('{int'(pix[0]), int'(ips[0]), int'(dp[0]), int'(dm[0])});
            if (ov[1] && out_ready) bq1.push_back('{int'(pix[1]), int'(ips[1]), int'(dp[1]), int'(dm[1])});
            if (dn[0]) begin dpost0.push_back(int'(pix[0])); dip0.push_back(int'(ips[0])); end
            if (dn[1]) begin dpost1.push_back(int'(pix[1])); dov1.push_back(int'(ov[1])); end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_counts();
        for (int i = 0; i < NI; i++) count[i*8 +: 8] = cnt_arr[i];
    endtask

    task automatic ramp_counts();
        for (int i = 0; i < NI; i++) cnt_arr[i] = 8'(i);
        set_counts();
    endtask

    task automatic clr_q();
        bq0.delete(); bq1.delete(); dpost0.delete(); dpost1.delete(); dip0.delete(); dov1.delete();
    endtask

    task automatic fire(input logic [15:0] m);
        start_wch = m;
        tick();
        start_wch = '0;
    endtask

    function automatic bit model_idle();
        return !m_act[0] && !m_act[1] && m_pend[0] == 0 && m_pend[1] == 0;
    endfunction

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (!model_idle() && n < 3000) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        check_eq("idle_reached", n < 3000, 1);
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bit ok, found;
        start_wch = '0;
        out_ready = 1'b1;
        ramp_counts();
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check_eq("rst_out_valid", ov[0], 0);
        check_eq("rst_busy", bsy[0], 0);
        check_eq("rst_post_idx", pix[0], 0);
        check_eq("rst_del_w_plus", dp[0], 0);
        tick();

        // single fire, latency and content
        clr_q();
        start_wch = 16'h0004;
        @(posedge clk);
        #1 start_wch = '0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            if (ov[0]) break;
            lat++;
        end
        check_eq("t1_latency", lat, 3);
        wait_idle(0);
        check_eq("t1_beats", bq0.size(), 8);
        check_eq("t1_dones", dpost0.size(), 1);
        if (bq0.size() == 8) begin
            check_eq("t1_post", bq0[0].post, 2);
            check_eq("t1_plus0", bq0[0].plus, 1000);
            check_eq("t1_minus7", bq0[7].minus, 52);
        end
        if (dip0.size() == 1) check_eq("t1_done_ip", dip0[0], 7);

        // merged and queued fires, back-to-back sweeps
        clr_q();
        fire(16'h0011);
        repeat (5) tick();
        fire(16'h0100);
        wait_idle(0);
        check_eq("t2_dones", dpost0.size(), 3);
        check_eq("t2_beats", bq0.size(), 24);
        if (dpost0.size() == 3) begin
            check_eq("t2_order0", dpost0[0], 0);
            check_eq("t2_order1", dpost0[1], 4);
            check_eq("t2_order2", dpost0[2], 8);
        end
        check_eq("t2_skip_dones", dpost1.size(), 3);

        // alternating backpressure
        clr_q();
        fire(16'h0001);
        for (int i = 0; i < 40; i++) begin
            out_ready = i[0];
            tick();
        end
        wait_idle(0);
        ok = (bq0.size() == 8);
        for (int i = 0; i < bq0.size(); i++) if (bq0[i].ip != i) ok = 0;
        check_eq("t3_order", ok, 1);
        check_eq("t3_skip_beats", bq1.size(), 7);

        // zero skipping
        clr_q();
        for (int i = 0; i < NI; i++) cnt_arr[i] = 8'd0;
        cnt_arr[1] = 8'd3;
        cnt_arr[4] = 8'd5;
        set_counts();
        fire(16'h0001);
        wait_idle(0);
        check_eq("t4_beats", bq1.size(), 2);
        check_eq("t4_full_beats", bq0.size(), 8);
        if (bq1.size() == 2) begin
            check_eq("t4_ip_a", bq1[0].ip, 1);
            check_eq("t4_plus_a", bq1[0].plus, 1021);
            check_eq("t4_ip_b", bq1[1].ip, 4);
            check_eq("t4_minus_b", bq1[1].minus, 28);
        end
        check_eq("t4_dones", dov1.size(), 1);
        if (dov1.size() == 1) check_eq("t4_done_ov", dov1[0], 0);

        // reset mid-sweep
        ramp_counts();
        clr_q();
        fire(16'h0001);
        tick();
        fire(16'h0002);
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (ov[0] && ips[0] == 3'd4) found = 1;
        end
        check_eq("t5_beat4_seen", found, 1);
        #1 rst = 1'b1;
        #1 check_eq("t5_done_in_rst", dn, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("t5_out_valid", ov, 2'b00);
        check_eq("t5_busy", bsy, 2'b00);
        check_eq("t5_post", pix[0], 0);
        check_eq("t5_ip", ips[0], 0);
        check_eq("t5_plus", dp[0], 0);
        bq0.delete();
        repeat (30) tick();
        check_eq("t5_no_beats", bq0.size(), 0);
        check_eq("t5_no_done", dpost0.size() + dpost1.size(), 0);

        // refire of the neuron being swept
        clr_q();
        fire(16'h0008);
        for (int n = 0; n < 20 && bq0.size() < 2; n++) tick();
        fire(16'h0008);
        wait_idle(0);
        check_eq("t6_dones", dpost0.size(), 2);
        check_eq("t6_beats", bq0.size(), 16);
        if (dpost0.size() == 2) check_eq("t6_post", dpost0[1], 3);

        // randomized traffic
        for (int ep = 0; ep < 25; ep++) begin
            for (int i = 0; i < NI; i++)
                cnt_arr[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            set_counts();
            for (int c = 0; c < 40; c++) begin
                start_wch = ($urandom_range(0, 4) == 0) ? (16'($urandom) & 16'($urandom)) : '0;
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            start_wch = '0;
            wait_idle(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
